// File: rtl/pixel_stream_pkg.sv
// Shared constants and types for the camera pixel stream stages.
package pixel_stream_pkg;
  localparam int SOF_BIT = 0;
  localparam int EOL_BIT = 1;

  localparam int ERR_LINE_SHORT = 0;
  localparam int ERR_LINE_LONG  = 1;
  localparam int ERR_EARLY_SOF  = 2;
  localparam int ERR_W          = 3;

  typedef enum logic {WAIT_SOF, IN_FRAME} tracker_state_t;
endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream buffer with registered ready; fully decouples ready paths.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);
  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count, count_next;
  logic             push, pop;

  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign m_valid = count != 2'd0;
  assign m_data  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 2'd1;
    else if (pop && !push) count_next = count - 2'd1;
  end

  // Ready looks at next occupancy so a full buffer can never be overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= 2'd0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      s_ready <= 1'b0;
      mem     <= '{default: '0};
    end else begin
      count   <= count_next;
      s_ready <= count_next != 2'd2;
      if (push) begin
        mem[wr_ptr] <= s_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
    end
  end
endmodule

// File: rtl/pixel_position_tracker.sv
// Tags each in-frame pixel with its column/row, checks line/frame framing and
// forwards the beat through a skid buffer with coordinates aligned to the data.
module pixel_position_tracker
  import pixel_stream_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int USER_WIDTH      = 2,
  parameter int IN_COLS         = 20,
  parameter int IN_ROWS         = 20,
  parameter int FRAME_CNT_WIDTH = 16,
  parameter int DROP_CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0]   s_axis_tdata,
  input  logic [USER_WIDTH-1:0]        s_axis_tuser,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [PIXEL_BIT_WIDTH-1:0]   m_axis_tdata,
  output logic [USER_WIDTH-1:0]        m_axis_tuser,
  output logic [$clog2(IN_COLS)-1:0]   cnt_col,
  output logic [$clog2(IN_ROWS)-1:0]   cnt_row,
  output logic                         frame_done,
  output logic [FRAME_CNT_WIDTH-1:0]   frame_count,
  output logic [DROP_CNT_WIDTH-1:0]    drop_count,
  output logic [ERR_W-1:0]             err_pulse,
  output logic [ERR_W-1:0]             err_sticky
);
  localparam int COL_W = $clog2(IN_COLS);
  localparam int ROW_W = $clog2(IN_ROWS);
  localparam int PAY_W = PIXEL_BIT_WIDTH + USER_WIDTH + COL_W + ROW_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_COLS - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_ROWS - 1);

  tracker_state_t      state, state_next;
  logic [COL_W-1:0]    col, col_next, fwd_col;
  logic [ROW_W-1:0]    row, row_next, fwd_row;
  logic                accept, sof, eol, fwd, done_next;
  logic [ERR_W-1:0]    err_next;
  logic [DROP_CNT_WIDTH-1:0] drop_next;

  assign accept = s_axis_tvalid && s_axis_tready;
  assign sof    = s_axis_tuser[SOF_BIT];
  assign eol    = s_axis_tuser[EOL_BIT];
  assign fwd    = sof || (state == IN_FRAME);

  // SOF always restarts at (0,0); EOL is only checked, never used to resync.
  always_comb begin
    state_next = state;
    col_next   = col;
    row_next   = row;
    err_next   = '0;
    done_next  = 1'b0;
    drop_next  = drop_count;
    fwd_col    = sof ? '0 : col;
    fwd_row    = sof ? '0 : row;
    if (accept) begin
      if (!fwd) begin
        if (drop_count != '1) drop_next = drop_count + 1'b1;
      end else begin
        state_next               = IN_FRAME;
        err_next[ERR_EARLY_SOF]  = sof && (state == IN_FRAME) && (col != '0 || row != '0);
        err_next[ERR_LINE_SHORT] = eol && (fwd_col != LAST_COL);
        err_next[ERR_LINE_LONG]  = !eol && (fwd_col == LAST_COL);
        if (fwd_col == LAST_COL) begin
          col_next = '0;
          if (fwd_row == LAST_ROW) begin
            row_next   = '0;
            done_next  = 1'b1;
            state_next = WAIT_SOF;
          end else begin
            row_next = fwd_row + 1'b1;
          end
        end else begin
          col_next = fwd_col + 1'b1;
          row_next = fwd_row;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_SOF;
      col         <= '0;
      row         <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      drop_count  <= '0;
      err_pulse   <= '0;
      err_sticky  <= '0;
    end else begin
      state       <= state_next;
      col         <= col_next;
      row         <= row_next;
      frame_done  <= done_next;
      frame_count <= frame_count + FRAME_CNT_WIDTH'(done_next);
      drop_count  <= drop_next;
      err_pulse   <= err_next;
      err_sticky  <= err_sticky | err_next;
    end
  end

  axis_skid_buffer #(.WIDTH(PAY_W)) u_skid (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_axis_tvalid && fwd),
    .s_ready (s_axis_tready),
    .s_data  ({s_axis_tdata, s_axis_tuser, fwd_col, fwd_row}),
    .m_valid (m_axis_tvalid),
    .m_ready (m_axis_tready),
    .m_data  ({m_axis_tdata, m_axis_tuser, cnt_col, cnt_row})
  );
endmodule

// File: tb/tb_pixel_position_tracker.sv
// Directed scoreboard bench for pixel_position_tracker on a 4x3 frame.
module tb_pixel_position_tracker;
  import pixel_stream_pkg::*;

  localparam int PW = 10, UW = 2, C = 4, R = 3, CW = 2, RW = 2, FW = 16, DW = 16;

  typedef struct packed {
    logic          vld;
    logic [PW-1:0] data;
    logic [UW-1:0] user;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
  } beat_t;

  logic clk = 1'b0, reset = 1'b1;
  logic s_axis_tvalid = 1'b0, m_axis_tready = 1'b1;
  logic s_axis_tready, m_axis_tvalid, frame_done;
  logic [PW-1:0] s_axis_tdata = '0, m_axis_tdata;
  logic [UW-1:0] s_axis_tuser = '0, m_axis_tuser;
  logic [CW-1:0] cnt_col;
  logic [RW-1:0] cnt_row;
  logic [FW-1:0] frame_count;
  logic [DW-1:0] drop_count;
  logic [2:0]    err_pulse, err_sticky;

  pixel_position_tracker #(
    .PIXEL_BIT_WIDTH(PW), .USER_WIDTH(UW), .IN_COLS(C), .IN_ROWS(R),
    .FRAME_CNT_WIDTH(FW), .DROP_CNT_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser),
    .cnt_col(cnt_col), .cnt_row(cnt_row),
    .frame_done(frame_done), .frame_count(frame_count), .drop_count(drop_count),
    .err_pulse(err_pulse), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0, dseq = 1, fd_cnt = 0, rdy_mode = 0;
  bit lat_chk = 1'b0;
  beat_t exp_q[$];
  int    lat_q[$];
  beat_t got, exp_b, prev_b;
  int    acc_cyc;
  bit    prev_stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // 0: ready high, 1: toggle every cycle, otherwise: held low
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       m_axis_tready = 1'b1;
      1:       m_axis_tready = ~m_axis_tready;
      default: m_axis_tready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      got = '{m_axis_tvalid, m_axis_tdata, m_axis_tuser, cnt_col, cnt_row};
      if (prev_stall) chk("stable_under_stall", 32'(got), 32'(prev_b));
      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_b   = exp_q.pop_front();
          acc_cyc = lat_q.pop_front();
          chk("beat", 32'(got), 32'(exp_b));
          if (lat_chk) chk("latency", 32'(cyc - acc_cyc), 32'd1);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_b     = got;
    end
  end

  task automatic beat(input logic [UW-1:0] user, input bit fwd, input int col, input int row);
    int n;
    beat_t b;
    s_axis_tdata  = PW'(dseq);
    s_axis_tuser  = user;
    s_axis_tvalid = 1'b1;
    dseq++;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_axis_tready && n < 300);
    chk("accept_timeout", 32'(s_axis_tready), 32'd1);
    if (fwd) begin
      b = '{1'b1, s_axis_tdata, user, CW'(col), RW'(row)};
      exp_q.push_back(b);
      lat_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic frame_beats(input int from, input int to, input int eol_extra);
    logic [UW-1:0] u;
    for (int i = from; i <= to; i++) begin
      u[SOF_BIT] = (i == 0);
      u[EOL_BIT] = (i % C == C - 1) || (i == eol_extra);
      beat(u, 1'b1, i % C, i / C);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0, first;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_axis_tready), 32'd0);
    chk("rst_m_valid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_counts", 32'({frame_count, drop_count}), 32'd0);
    chk("rst_err", 32'({err_pulse, err_sticky, frame_done}), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(s_axis_tready), 32'd1);

    // clean frame
    lat_chk = 1'b1;
    fd0 = fd_cnt;
    frame_beats(0, 11, -1);
    chk("clean_done_pulse", 32'(frame_done), 32'd1);
    chk("clean_fc", 32'(frame_count), 32'd1);
    drain();
    lat_chk = 1'b0;
    chk("clean_fd_count", 32'(fd_cnt - fd0), 32'd1);
    chk("clean_sticky", 32'(err_sticky), 32'd0);

    // pre-SOF garbage
    for (int i = 0; i < 5; i++) beat(2'b00, 1'b0, 0, 0);
    chk("drop_count", 32'(drop_count), 32'd5);
    frame_beats(0, 11, -1);
    drain();
    chk("garbage_fc", 32'(frame_count), 32'd2);

    // backpressure: toggling ready, then held low with a full buffer
    rdy_mode = 1;
    frame_beats(0, 11, -1);
    rdy_mode = 0;
    drain();
    chk("bp_fc", 32'(frame_count), 32'd3);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    first = dseq;
    frame_beats(0, 1, -1);
    chk("bp_ready_full", 32'(s_axis_tready), 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'({s_axis_tready, m_axis_tvalid, m_axis_tdata}), 32'({1'b0, 1'b1, PW'(first)}));
    end
    rdy_mode = 0;
    frame_beats(2, 11, -1);
    drain();
    chk("bp2_fc", 32'(frame_count), 32'd4);

    // short line: EOL at column 2 of row 0
    frame_beats(0, 2, 2);
    chk("short_pulse", 32'(err_pulse), 32'b001);
    chk("short_sticky", 32'(err_sticky), 32'b001);
    frame_beats(3, 3, -1);
    chk("short_pulse_clear", 32'(err_pulse), 32'd0);
    frame_beats(4, 11, -1);
    drain();
    chk("short_fc", 32'(frame_count), 32'd5);

    // reset mid-frame with a beat stuck in the buffer
    frame_beats(0, 5, -1);
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    frame_beats(6, 6, -1);
    reset = 1'b1;
    exp_q.delete();
    lat_q.delete();
    @(posedge clk);
    #1;
    chk("mrst_m_valid", 32'(m_axis_tvalid), 32'd0);
    chk("mrst_counts", 32'({frame_count, drop_count}), 32'd0);
    chk("mrst_err", 32'({err_pulse, err_sticky, frame_done}), 32'd0);
    reset = 1'b0;
    rdy_mode = 0;
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_no_stale", 32'(m_axis_tvalid), 32'd0);

    // early SOF at (1,1)
    frame_beats(0, 4, -1);
    beat(2'b01, 1'b1, 0, 0);
    chk("early_pulse", 32'(err_pulse), 32'b100);
    for (int j = 1; j < C * R; j++) begin
      chk("early_fc_hold", 32'(frame_count), 32'd0);
      beat({1'(j % C == C - 1), 1'b0}, 1'b1, j % C, j / C);
    end
    chk("early_done", 32'({frame_done, frame_count}), 32'({1'b1, FW'(1)}));
    chk("early_sticky", 32'(err_sticky), 32'b100);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
